// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: CPU-side request bus and RAM-side strobe bus for mem_access_ctrl
interface mem_cpu_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_SPACE = 9
);
  logic req, we, ready, done, err;
  logic [ADDR_SPACE-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata, rdata;
  modport master(output req, we, addr, wdata, input ready, done, rdata, err);
  modport slave(input req, we, addr, wdata, output ready, done, rdata, err);
endinterface

interface mem_ram_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_SPACE = 9
);
  logic read, write, enable;
  logic [ADDR_SPACE-1:0] addr;
  logic [DATA_WIDTH-1:0] datain, dataout;
  modport master(output addr, datain, read, write, enable, input dataout);
  modport slave(input addr, datain, read, write, enable, output dataout);
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-word RAM access sequencer with registered enable strobe; MEM_WRITE_READBACK_EN adds write verify
module mem_access_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_SPACE = 9,
  parameter int STROBE_CYCLES = 1
) (
  input logic clock,
  input logic reset,
  mem_cpu_if.slave cpu,
  mem_ram_if.master ram
);
  typedef enum logic [2:0] {
    IDLE, SETUP, STROBE, HOLD, DONE
`ifdef MEM_WRITE_READBACK_EN
    , VSETUP, VSTROBE, VHOLD
`endif
  } state_t;
  state_t state, state_n;
  logic [3:0] cnt;
  logic we_q, we_n, last, pri, ver, en_n, rd_n, wr_n;
  logic [ADDR_SPACE-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  assign last = cnt == 4'(STROBE_CYCLES - 1);
  assign we_n = state == IDLE ? cpu.we : we_q;
  assign cpu.ready = state == IDLE;
  assign ram.addr = addr_q;
  assign ram.datain = wdata_q;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = cpu.req ? SETUP : IDLE;
      SETUP: state_n = STROBE;
      STROBE: state_n = last ? HOLD : STROBE;
`ifdef MEM_WRITE_READBACK_EN
      HOLD: state_n = we_q ? VSETUP : DONE;
      VSETUP: state_n = VSTROBE;
      VSTROBE: state_n = last ? VHOLD : VSTROBE;
      VHOLD: state_n = DONE;
`else
      HOLD: state_n = DONE;
`endif
      default: state_n = IDLE;
    endcase
    pri = state_n inside {SETUP, STROBE, HOLD};
    ver = 1'b0;
    en_n = state_n == STROBE;
`ifdef MEM_WRITE_READBACK_EN
    ver = state_n inside {VSETUP, VSTROBE, VHOLD};
    en_n = state_n inside {STROBE, VSTROBE};
`endif
    rd_n = (pri & ~we_n) | ver;
    wr_n = pri & we_n;
  end
  // RAM strobes are registered from the next state so enable rises cleanly one cycle after addr/data settle
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      ram.read <= 1'b0;
      ram.write <= 1'b0;
      ram.enable <= 1'b0;
      cpu.done <= 1'b0;
      cpu.rdata <= '0;
    end else begin
      state <= state_n;
      cnt <= (state_n == state && state != IDLE) ? cnt + 4'd1 : 4'd0;
      ram.enable <= en_n;
      ram.read <= rd_n;
      ram.write <= wr_n;
      cpu.done <= state_n == DONE;
      if (state == IDLE && cpu.req) begin
        we_q <= cpu.we;
        addr_q <= cpu.addr;
        wdata_q <= cpu.wdata;
      end
      if (state == HOLD && !we_q) cpu.rdata <= ram.dataout;
`ifdef MEM_WRITE_READBACK_EN
      if (state == VHOLD) cpu.rdata <= ram.dataout;
`endif
    end
  end
`ifdef MEM_WRITE_READBACK_EN
  always_ff @(posedge clock) begin
    if (reset || (state == IDLE && cpu.req)) cpu.err <= 1'b0;
    else if (state == VHOLD) cpu.err <= ram.dataout != wdata_q;
  end
`else
  assign cpu.err = 1'b0;
`endif
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: scoreboard bench for mem_access_ctrl driving a behavioural 512x32 RAM stub
module tb_mem_access_ctrl;
  localparam int DW = 32, AW = 9, N = 1;
  typedef struct {
    logic [31:0] rdata;
    logic err;
    int acc;
    int lat;
    int edges;
  } exp_t;
  logic clock = 1'b0, reset = 1'b1, corrupt = 1'b0, en_prev = 1'b0;
  logic [31:0] m_rdata = '0;
  logic [31:0] mmem [512];
  logic [31:0] ram_mem [512];
  exp_t q[$];
  int tests = 0, fails = 0, cyc = 0, next_free = 0, n_acc = 0, n_done = 0, last_acc = 0, en_edges = 0, en_hi = 0;
  always #5 clock = ~clock;
  mem_cpu_if #(.DATA_WIDTH(DW), .ADDR_SPACE(AW)) cpu();
  mem_ram_if #(.DATA_WIDTH(DW), .ADDR_SPACE(AW)) ram();
  mem_access_ctrl #(.DATA_WIDTH(DW), .ADDR_SPACE(AW), .STROBE_CYCLES(N)) dut (
    .clock(clock), .reset(reset), .cpu(cpu), .ram(ram)
  );
  function automatic logic [31:0] preload(int i);
    return i == 0 ? 32'h9B180019 : 32'h10000000 + 32'(i) * 32'h01010101;
  endfunction
  initial for (int i = 0; i < 512; i++) mmem[i] = preload(i);
  initial for (int i = 0; i < 512; i++) ram_mem[i] = preload(i);
  // RAM stub samples on the rising edge of enable; corrupt flips bit 0 of read data
  always @(posedge ram.enable) begin
    if (ram.write) ram_mem[ram.addr] <= ram.datain;
    if (ram.read) ram.dataout <= ram_mem[ram.addr] ^ {31'b0, corrupt};
  end
  always @(negedge clock) begin
    exp_t e;
    cyc++;
    tests += 2;
    if (cpu.ready !== (cyc >= next_free)) begin
      fails++;
      $display("FAIL ready cyc=%0d got=%b exp=%b", cyc, cpu.ready, cyc >= next_free);
    end
    if (ram.read === 1'b1 && ram.write === 1'b1) begin
      fails++;
      $display("FAIL rw_both cyc=%0d got read=1 write=1 exp not both", cyc);
    end
    if (ram.enable === 1'b1 && !en_prev) en_edges++;
    if (ram.enable === 1'b1) en_hi++;
    en_prev = ram.enable === 1'b1;
    if (cpu.done === 1'b1) begin
      n_done++;
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL done_unexpected cyc=%0d got done=1 exp 0", cyc);
      end else begin
        e = q.pop_front();
        tests += 4;
        if (cpu.rdata !== e.rdata) begin
          fails++;
          $display("FAIL rdata cyc=%0d got=%h exp=%h", cyc, cpu.rdata, e.rdata);
        end
        if (cpu.err !== e.err) begin
          fails++;
          $display("FAIL err cyc=%0d got=%b exp=%b", cyc, cpu.err, e.err);
        end
        if (cyc - e.acc !== e.lat) begin
          fails++;
          $display("FAIL latency cyc=%0d got=%0d exp=%0d", cyc, cyc - e.acc, e.lat);
        end
        if (en_edges !== e.edges || en_hi !== e.edges * N) begin
          fails++;
          $display("FAIL enable cyc=%0d got edges=%0d high=%0d exp edges=%0d high=%0d", cyc, en_edges, en_hi, e.edges, e.edges * N);
        end
      end
    end
    if (reset) begin
      q.delete();
      next_free = cyc + 1;
      m_rdata = '0;
    end else if (cyc >= next_free && cpu.req) begin
      e.acc = cyc;
      e.lat = 3 + N;
      e.edges = 1;
      e.err = 1'b0;
      next_free = cyc + 4 + N;
      if (cpu.we) begin
        mmem[cpu.addr] = cpu.wdata;
`ifdef MEM_WRITE_READBACK_EN
        m_rdata = cpu.wdata ^ {31'b0, corrupt};
        e.err = corrupt;
        e.lat += 2 + N;
        e.edges = 2;
        next_free += 2 + N;
`endif
      end else m_rdata = mmem[cpu.addr];
      e.rdata = m_rdata;
      q.push_back(e);
      n_acc++;
      last_acc = cyc;
      en_edges = 0;
      en_hi = 0;
    end
  end
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 100 && (q.size() != 0 || cyc < next_free); i++) begin
      @(negedge clock);
      #1;
    end
    tests++;
    if (q.size() != 0 || cyc < next_free) begin
      fails++;
      $display("FAIL idle_timeout got pending=%0d exp 0", q.size());
    end
  endtask
  task automatic do_access(input logic w, input logic [8:0] a, input logic [31:0] d);
    step();
    cpu.we = w;
    cpu.addr = a;
    cpu.wdata = d;
    cpu.req = 1'b1;
    step();
    cpu.req = 1'b0;
    wait_idle();
  endtask
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    tests += 5;
    if (cpu.ready !== 1'b1) begin fails++; $display("FAIL reset_ready got=%b exp=1", cpu.ready); end
    if ({ram.enable, ram.read, ram.write} !== 3'b000) begin
      fails++;
      $display("FAIL reset_strobes got=%b exp=000", {ram.enable, ram.read, ram.write});
    end
    if ({cpu.done, cpu.err} !== 2'b00) begin fails++; $display("FAIL reset_done_err got=%b exp=00", {cpu.done, cpu.err}); end
    if (cpu.rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata got=%h exp=0", cpu.rdata); end
    if ({ram.addr, ram.datain} !== 41'h0) begin fails++; $display("FAIL reset_addr_data got=%h exp=0", {ram.addr, ram.datain}); end
    reset = 1'b0;
    step();
    tests++;
    if (cpu.ready !== 1'b1) begin fails++; $display("FAIL post_reset_ready got=%b exp=1", cpu.ready); end
  endtask
  task automatic test_read0();
    do_access(1'b0, 9'h000, 32'h0);
    tests += 2;
    if (cpu.rdata !== 32'h9B180019) begin fails++; $display("FAIL read0 got=%h exp=9b180019", cpu.rdata); end
    if (cpu.done !== 1'b0) begin fails++; $display("FAIL read0_done_pulse got=%b exp=0", cpu.done); end
  endtask
  task automatic test_write_read();
    do_access(1'b1, 9'h005, 32'hDEADBEEF);
    tests++;
`ifdef MEM_WRITE_READBACK_EN
    if (cpu.rdata !== 32'hDEADBEEF) begin fails++; $display("FAIL write_rdata got=%h exp=deadbeef", cpu.rdata); end
`else
    if (cpu.rdata !== 32'h9B180019) begin fails++; $display("FAIL write_rdata got=%h exp=9b180019", cpu.rdata); end
`endif
    do_access(1'b0, 9'h005, 32'h0);
    tests++;
    if (cpu.rdata !== 32'hDEADBEEF) begin fails++; $display("FAIL readback5 got=%h exp=deadbeef", cpu.rdata); end
  endtask
  task automatic test_back_to_back();
    int n0, prev, iv;
    logic prev_we;
    prev = 0;
    prev_we = 1'b0;
    step();
    for (int k = 0; k < 4; k++) begin
      cpu.we = k % 2 == 0;
      cpu.addr = k < 2 ? 9'h1FF : 9'h000;
      cpu.wdata = 32'hA5A50000 + 32'(k);
      cpu.req = 1'b1;
      n0 = n_acc;
      for (int i = 0; i < 40 && n_acc == n0; i++) begin
        @(negedge clock);
        #1;
      end
      tests++;
      if (n_acc == n0) begin fails++; $display("FAIL b2b_accept_timeout k=%0d got no acceptance", k); end
      iv = 4 + N;
`ifdef MEM_WRITE_READBACK_EN
      if (prev_we) iv += 2 + N;
`endif
      if (k > 0) begin
        tests++;
        if (last_acc - prev !== iv) begin fails++; $display("FAIL b2b_interval k=%0d got=%0d exp=%0d", k, last_acc - prev, iv); end
      end
      prev = last_acc;
      prev_we = cpu.we;
      step();
    end
    cpu.req = 1'b0;
    wait_idle();
    tests++;
    if (cpu.rdata !== 32'hA5A50002) begin fails++; $display("FAIL b2b_rdata got=%h exp=a5a50002", cpu.rdata); end
  endtask
  task automatic test_reset_mid();
    int d0;
    d0 = n_done;
    step();
    cpu.we = 1'b1;
    cpu.addr = 9'h010;
    cpu.wdata = 32'h0BADF00D;
    cpu.req = 1'b1;
    step();
    cpu.req = 1'b0;
    step();
    tests++;
    if (ram.enable !== 1'b1) begin fails++; $display("FAIL mid_strobe_enable got=%b exp=1", ram.enable); end
    reset = 1'b1;
    step();
    tests += 2;
    if ({ram.enable, ram.read, ram.write, cpu.done} !== 4'b0000) begin
      fails++;
      $display("FAIL mid_reset_strobes got=%b exp=0000", {ram.enable, ram.read, ram.write, cpu.done});
    end
    if (cpu.ready !== 1'b1) begin fails++; $display("FAIL mid_reset_ready got=%b exp=1", cpu.ready); end
    reset = 1'b0;
    repeat (8) step();
    tests += 2;
    if (n_done !== d0) begin fails++; $display("FAIL mid_reset_no_done got=%0d exp=%0d", n_done - d0, 0); end
    if (cpu.ready !== 1'b1) begin fails++; $display("FAIL mid_reset_idle got=%b exp=1", cpu.ready); end
  endtask
  task automatic test_req_ignore();
    int d0;
    d0 = n_done;
    step();
    cpu.we = 1'b0;
    cpu.addr = 9'h005;
    cpu.req = 1'b1;
    step();
    cpu.addr = 9'h007;
    step();
    step();
    cpu.req = 1'b0;
    step();
    cpu.req = 1'b1;
    step();
    cpu.req = 1'b0;
    wait_idle();
    repeat (6) step();
    tests += 2;
    if (n_done - d0 !== 1) begin fails++; $display("FAIL ignore_done_count got=%0d exp=1", n_done - d0); end
    if (cpu.rdata !== 32'hDEADBEEF) begin fails++; $display("FAIL ignore_rdata got=%h exp=deadbeef", cpu.rdata); end
  endtask
  task automatic test_readback();
    corrupt = 1'b1;
    do_access(1'b1, 9'h020, 32'h00000001);
    tests += 2;
`ifdef MEM_WRITE_READBACK_EN
    if (cpu.err !== 1'b1) begin fails++; $display("FAIL rb_corrupt_err got=%b exp=1", cpu.err); end
    if (cpu.rdata !== 32'h0) begin fails++; $display("FAIL rb_corrupt_rdata got=%h exp=0", cpu.rdata); end
`else
    if (cpu.err !== 1'b0) begin fails++; $display("FAIL rb_corrupt_err got=%b exp=0", cpu.err); end
    if (cpu.rdata !== 32'hDEADBEEF) begin fails++; $display("FAIL rb_corrupt_rdata got=%h exp=deadbeef", cpu.rdata); end
`endif
    corrupt = 1'b0;
    do_access(1'b1, 9'h021, 32'h12345678);
    tests += 2;
    if (cpu.err !== 1'b0) begin fails++; $display("FAIL rb_clean_err got=%b exp=0", cpu.err); end
`ifdef MEM_WRITE_READBACK_EN
    if (cpu.rdata !== 32'h12345678) begin fails++; $display("FAIL rb_clean_rdata got=%h exp=12345678", cpu.rdata); end
`else
    if (cpu.rdata !== 32'hDEADBEEF) begin fails++; $display("FAIL rb_clean_rdata got=%h exp=deadbeef", cpu.rdata); end
`endif
  endtask
  initial begin
    cpu.req = 1'b0;
    cpu.we = 1'b0;
    cpu.addr = '0;
    cpu.wdata = '0;
    test_reset();
    test_read0();
    test_write_read();
    test_back_to_back();
    test_reset_mid();
    test_req_ignore();
    test_readback();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
